// File: rtl/ram_pipe.sv
// Simple dual-port RAM with lane write masks, 1- or 2-stage read pipeline,
// selectable read-during-write result, tri-state read bus and post-reset clear.
module ram_pipe #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 16,
  parameter int LANE_WIDTH    = 4,
  parameter int RD_LATENCY    = 1,
  parameter int RDW_MODE      = 0,
  parameter int INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             we,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wm,
  input  logic [ADDR_WIDTH-1:0]            aw,
  input  logic [DATA_WIDTH-1:0]            x,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            ar,
  output tri   [DATA_WIDTH-1:0]            y,
  output logic                             y_valid,
  output logic                             busy
);
  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane
    $error("ram_pipe: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
    $error("ram_pipe: RD_LATENCY must be 1 or 2");
  end

  typedef enum logic {INIT, READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    wr_en, rd_en, rd_bypass;
  logic [DATA_WIDTH-1:0]   rd_raw, rd_data, d1, d2;
  logic [2:1]              vld_pipe;

  assign busy  = (state == INIT);
  assign wr_en = we && !busy;
  assign rd_en = re && !busy;

  // Clear sequencer: one word per edge, leaves INIT after writing the last address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      if (INIT_ON_RESET != 0) state <= INIT;
      else                    state <= READY;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (&cnt) state <= READY;
    end
  end

  // Array has no reset; gating on rst_n keeps held-reset edges from scribbling m[0]
  always_ff @(posedge clk) begin
    if (busy) begin
      if (rst_n) mem[cnt] <= INIT_VALUE;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++)
        if (wm[i]) mem[aw][i*LANE_WIDTH +: LANE_WIDTH] <= x[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  assign rd_raw    = mem[ar];
  assign rd_bypass = (RDW_MODE != 0) && wr_en && (ar == aw);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign rd_data[i*LANE_WIDTH +: LANE_WIDTH] = (rd_bypass && wm[i])
      ? x[i*LANE_WIDTH +: LANE_WIDTH] : rd_raw[i*LANE_WIDTH +: LANE_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[1], rd_en};
  end

  // Data stages need no reset: they are only observable through the valid bits
  always_ff @(posedge clk) begin
    if (rd_en)       d1 <= rd_data;
    if (vld_pipe[1]) d2 <= d1;
  end

  assign y_valid = vld_pipe[RD_LATENCY];
  assign y = y_valid ? ((RD_LATENCY == 2) ? d2 : d1) : {DATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_ram_pipe.sv
// Directed bench for ram_pipe: u0 is latency 2 / old-data RDW, u1 is latency 1 / new-data RDW.
module tb_ram_pipe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       we, re;
  logic [1:0] wm;
  logic [3:0] aw, ar;
  logic [7:0] x;
  tri   [7:0] y0, y1;
  logic       yv0, yv1, busy0, busy1;
  int         errors = 0;
  int         checks = 0;

  // Pull-ups make a released bus read as all-ones
  pullup (y0);
  pullup (y1);

  always #5 clk = ~clk;

  ram_pipe #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LANE_WIDTH(4), .RD_LATENCY(2), .RDW_MODE(0),
             .INIT_ON_RESET(1), .INIT_VALUE(8'hA5)) u0 (
    .clk(clk), .rst_n(rst_n), .we(we), .wm(wm), .aw(aw), .x(x), .re(re), .ar(ar),
    .y(y0), .y_valid(yv0), .busy(busy0));

  ram_pipe #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LANE_WIDTH(4), .RD_LATENCY(1), .RDW_MODE(1),
             .INIT_ON_RESET(1), .INIT_VALUE(8'hA5)) u1 (
    .clk(clk), .rst_n(rst_n), .we(we), .wm(wm), .aw(aw), .x(x), .re(re), .ar(ar),
    .y(y1), .y_valid(yv1), .busy(busy1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [1:0] m, input logic [7:0] d);
    we = 1'b1; aw = a; wm = m; x = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b0; re = 1'b0; wm = 2'b00; aw = '0; ar = '0; x = '0;
    #2;
    checks++; if (busy0 !== 1'b1 || busy1 !== 1'b1) begin errors++; $display("FAIL reset_busy got %b %b want 1 1", busy0, busy1); end
    checks++; if (yv0 !== 1'b0 || yv1 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b %b want 0 0", yv0, yv1); end
    checks++; if (y0 !== 8'hFF || y1 !== 8'hFF) begin errors++; $display("FAIL reset_bus got %h %h want released", y0, y1); end
    tick(); tick();
  endtask

  task automatic test_clear();
    int n = 0;
    we = 1'b1; aw = 4'd3; wm = 2'b11; x = 8'h00;
    rst_n = 1'b1;
    while (n < 40) begin
      tick(); n++;
      if (!busy0) break;
    end
    we = 1'b0;
    checks++; if (n != 16) begin errors++; $display("FAIL clear_len got %0d edges want 16", n); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL clear_busy1 got %b want 0", busy1); end
    for (int a = 0; a < 16; a++) begin
      re = 1'b1; ar = a[3:0];
      tick();
      checks++; if (yv1 !== 1'b1 || y1 !== 8'hA5) begin errors++; $display("FAIL clear_rd1 addr %0d got %b/%h want 1/a5", a, yv1, y1); end
      if (a > 0) begin
        checks++; if (yv0 !== 1'b1 || y0 !== 8'hA5) begin errors++; $display("FAIL clear_rd0 addr %0d got %b/%h want 1/a5", a - 1, yv0, y0); end
      end
    end
    re = 1'b0;
    tick();
    checks++; if (yv0 !== 1'b1 || y0 !== 8'hA5) begin errors++; $display("FAIL clear_rd0 addr 15 got %b/%h want 1/a5", yv0, y0); end
    tick();
  endtask

  task automatic test_lane_mask();
    do_write(4'd5, 2'b11, 8'h00);
    do_write(4'd5, 2'b10, 8'h3C);
    re = 1'b1; ar = 4'd5; tick(); re = 1'b0;
    checks++; if (y1 !== 8'h30) begin errors++; $display("FAIL lane_hi got %h want 30", y1); end
    tick();
    do_write(4'd5, 2'b00, 8'hFF);
    re = 1'b1; ar = 4'd5; tick(); re = 1'b0;
    checks++; if (y1 !== 8'h30) begin errors++; $display("FAIL lane_none got %h want 30", y1); end
    tick();
    checks++; if (y0 !== 8'h30) begin errors++; $display("FAIL lane_none_u0 got %h want 30", y0); end
    tick();
  endtask

  task automatic test_latency();
    do_write(4'd1, 2'b11, 8'h11);
    do_write(4'd2, 2'b11, 8'h22);
    re = 1'b1; ar = 4'd1; tick();
    checks++; if (yv0 !== 1'b0) begin errors++; $display("FAIL lat_early got %b want 0", yv0); end
    checks++; if (yv1 !== 1'b1 || y1 !== 8'h11) begin errors++; $display("FAIL lat1_a got %b/%h want 1/11", yv1, y1); end
    ar = 4'd2; tick(); re = 1'b0;
    checks++; if (yv0 !== 1'b1 || y0 !== 8'h11) begin errors++; $display("FAIL lat2_a got %b/%h want 1/11", yv0, y0); end
    checks++; if (yv1 !== 1'b1 || y1 !== 8'h22) begin errors++; $display("FAIL lat1_b got %b/%h want 1/22", yv1, y1); end
    tick();
    checks++; if (yv0 !== 1'b1 || y0 !== 8'h22) begin errors++; $display("FAIL lat2_b got %b/%h want 1/22", yv0, y0); end
    checks++; if (yv1 !== 1'b0 || y1 !== 8'hFF) begin errors++; $display("FAIL lat1_end got %b/%h want 0/released", yv1, y1); end
    tick();
    checks++; if (yv0 !== 1'b0 || y0 !== 8'hFF) begin errors++; $display("FAIL lat2_end got %b/%h want 0/released", yv0, y0); end
  endtask

  task automatic test_rdw();
    do_write(4'd7, 2'b11, 8'h12);
    we = 1'b1; re = 1'b1; aw = 4'd7; ar = 4'd7; wm = 2'b11; x = 8'hEF;
    tick(); we = 1'b0; re = 1'b0;
    checks++; if (y1 !== 8'hEF) begin errors++; $display("FAIL rdw_new got %h want ef", y1); end
    tick();
    checks++; if (y0 !== 8'h12) begin errors++; $display("FAIL rdw_old got %h want 12", y0); end
    re = 1'b1; tick(); re = 1'b0;
    checks++; if (y1 !== 8'hEF) begin errors++; $display("FAIL rdw_after1 got %h want ef", y1); end
    tick();
    checks++; if (y0 !== 8'hEF) begin errors++; $display("FAIL rdw_after0 got %h want ef", y0); end
    // Partial-lane collision: the new-data port must merge lanes
    we = 1'b1; re = 1'b1; wm = 2'b01; x = 8'h00;
    tick(); we = 1'b0; re = 1'b0;
    checks++; if (y1 !== 8'hE0) begin errors++; $display("FAIL rdw_merge got %h want e0", y1); end
    tick();
    checks++; if (y0 !== 8'hEF) begin errors++; $display("FAIL rdw_merge_old got %h want ef", y0); end
    tick();
  endtask

  task automatic test_independent();
    do_write(4'd4, 2'b11, 8'h44);
    we = 1'b1; aw = 4'd2; wm = 2'b11; x = 8'h55; re = 1'b1; ar = 4'd4;
    tick(); we = 1'b0;
    checks++; if (y1 !== 8'h44) begin errors++; $display("FAIL indep_rd got %h want 44", y1); end
    ar = 4'd2; tick(); re = 1'b0;
    checks++; if (y1 !== 8'h55) begin errors++; $display("FAIL indep_wr got %h want 55", y1); end
    checks++; if (y0 !== 8'h44) begin errors++; $display("FAIL indep_rd0 got %h want 44", y0); end
    tick();
    checks++; if (y0 !== 8'h55) begin errors++; $display("FAIL indep_wr0 got %h want 55", y0); end
    tick();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    re = 1'b1; ar = 4'd5; tick(); re = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (yv1 !== 1'b0 || y1 !== 8'hFF) begin errors++; $display("FAIL mid_async1 got %b/%h want 0/released", yv1, y1); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy0); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (yv0 !== 1'b0 || y0 !== 8'hFF) begin errors++; $display("FAIL mid_flush0 got %b/%h want 0/released", yv0, y0); end
    repeat (8) tick();
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL mid_cnt9 got %b want 1", busy0); end
    rst_n = 1'b0;
    #1;
    checks++; if (yv0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL mid_rst2 got %b/%b want 0/1", yv0, busy0); end
    rst_n = 1'b1;
    while (n < 40) begin
      tick(); n++;
      if (!busy0) break;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL mid_restart_len got %0d edges want 16", n); end
    re = 1'b1; ar = 4'd7; tick();
    checks++; if (y1 !== 8'hA5) begin errors++; $display("FAIL mid_clr7 got %h want a5", y1); end
    ar = 4'd15; tick(); re = 1'b0;
    checks++; if (y1 !== 8'hA5) begin errors++; $display("FAIL mid_clr15 got %h want a5", y1); end
    tick();
  endtask

  initial begin
    test_reset();
    test_clear();
    test_lane_mask();
    test_latency();
    test_rdw();
    test_independent();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ram_pipe.md
Name: ram_pipe

Overview:
- Parametrised simple dual-port synchronous RAM: one write port, one read port, one clock.
- Adds per-lane write masks, selectable read latency (1 or 2), and selectable read-during-write behaviour.
- Adds a per-request read-valid strobe, tri-state read output gated by that strobe, and a post-reset memory-clear sequencer.
- Drop-in successor for data/program memories on the shared tri-state data bus.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of LANE_WIDTH (elaboration error otherwise)
ADDR_WIDTH, 16, address width; DEPTH = 2**ADDR_WIDTH words
LANE_WIDTH, 4, write-mask granularity in bits; LANES = DATA_WIDTH/LANE_WIDTH
RD_LATENCY, 1, read latency in clock edges; legal values 1 or 2 (elaboration error otherwise)
RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new (merged) data
INIT_ON_RESET, 1, 1 = clear memory to INIT_VALUE after reset; 0 = no clear, contents undefined
INIT_VALUE, 0, DATA_WIDTH-bit fill word used by the clear sequencer

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
we  input  1  write request
wm  input  LANES  write lane mask; bit i enables x[i*LANE_WIDTH +: LANE_WIDTH]
aw  input  ADDR_WIDTH  write address
x  input  DATA_WIDTH  write data
re  input  1  read request
ar  input  ADDR_WIDTH  read address
y  output (tri)  DATA_WIDTH  read data; driven only while y_valid=1, otherwise all-z
y_valid  output  1  read data valid strobe
busy  output  1  high while the clear sequencer runs; requests are ignored while high

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous, active-low.
- Reset asserted, immediately and without waiting for a clock edge:
  - y_valid=0, y=z, all read pipeline valid bits cleared.
  - Clear counter cleared to 0.
  - busy=1 if INIT_ON_RESET=1, else busy=0.
  - Memory array is not reset asynchronously.
- FSM states: INIT, READY.
  - INIT_ON_RESET=0: reset enters READY.
  - INIT_ON_RESET=1: reset enters INIT.
  - INIT: each edge writes INIT_VALUE to m[cnt] and increments cnt.
  - INIT exit: at the edge that writes address DEPTH-1, go to READY; busy falls after that edge.
  - Clear takes exactly DEPTH edges after rst_n deasserts.
  - Reset asserted during INIT restarts the clear from address 0.
- While busy=1:
  - we and re are ignored.
  - No user writes occur and no read requests enter the pipeline.
  - y_valid stays 0.
- Write (READY): at an edge with we=1, for each i with wm[i]=1, m[aw] lane i takes x lane i; lanes with wm[i]=0 are unchanged.
  - wm = all zeros is a no-op.
- Read (READY): a request accepted at edge N (re=1) returns data for ar as sampled at edge N.
  - RD_LATENCY=1: y_valid=1 and y=data after edge N, until edge N+1.
  - RD_LATENCY=2: y_valid=1 and y=data after edge N+1, until edge N+2.
  - The stage-2 register loads only when stage-1 holds a valid entry.
- y_valid is a one-cycle strobe per request. Back-to-back requests keep y_valid continuously high, with data changing each cycle.
- After re deasserts, y_valid falls RD_LATENCY edges after the last accepted request, and y returns to z.
- Read-during-write, we=1 and re=1 on the same edge with ar==aw:
  - RDW_MODE=0: the read returns pre-write contents.
  - RDW_MODE=1: the read returns the merged word (x lanes where wm=1, old lanes elsewhere).
- Different addresses on the same edge: fully independent; both complete.
- Reads of never-written addresses with INIT_ON_RESET=0 return undefined (x in simulation).
- Read pipeline state is unaffected by writes after capture; captured data is not refreshed.

Test Plan:
- Clear sequence: ADDR_WIDTH=4, INIT_ON_RESET=1, INIT_VALUE=8'hA5, rst_n released.
  - Required: busy high for exactly 16 edges.
  - Required: a we=1 to addr 3 during busy is dropped.
  - Required: afterwards, reads of 0..15 all return 8'hA5.
- Lane mask: m[5]=8'h00, then we=1, wm=2'b10, x=8'h3C to addr 5.
  - Required: read addr 5 returns 8'h30.
  - Required: a further write with wm=2'b00 leaves 8'h30.
- Latency and strobe: RD_LATENCY=2, m[1]=8'h11, m[2]=8'h22, re=1 on two consecutive edges N, N+1 for addrs 1, 2.
  - Required: y_valid high for exactly two cycles starting after edge N+1.
  - Required: y=8'h11 then 8'h22, then z.
- Read-during-write: m[7]=8'h12, same edge we=1, re=1, aw=ar=7, wm=2'b11, x=8'hEF.
  - Required: y=8'h12 with RDW_MODE=0, y=8'hEF with RDW_MODE=1.
  - Required: a subsequent read returns 8'hEF in both modes.
- Reset mid-operation: assert rst_n=0 while a RD_LATENCY=2 read is in flight and the clear counter is at 9.
  - Required: y_valid=0 and y=z immediately, with no clock edge.
  - Required: after release, the clear restarts at address 0 and takes 16 edges.
- Independent ports: same edge we to addr 2 (x=8'h55) and re from addr 4 (holding 8'h44).
  - Required: y=8'h44.
  - Required: a next-cycle read of addr 2 returns 8'h55.
